// File: rtl/numbers_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : numbers_pkg
//  Brief    : Glyph ROM geometry shared with the sprite reader, score writer
//             FSM states and the decimal limit helper.
//  Revision : 1.0  initial release
// ============================================================================
package numbers_pkg;

    // Geometry of the numbers.mem glyph ROM (one glyph per decimal digit)
    localparam int c_glyph_width    = 24;
    localparam int c_glyph_height   = 24;
    localparam int c_glyph_num_imgs = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_COPY    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } writer_state_t;

    // 10^n, used to derive the largest score that fits in n decimal digits
    function automatic int pow10(input int n);
        int acc;
        acc = 1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 10;
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_converter
//  Brief    : Sequential double-dabble, one shift per clock, VALUE_W shifts.
//             o_done is high during the cycle whose closing edge performs the
//             final shift; o_bcd holds the result from the following cycle.
//             o_bcd[3:0] is the least-significant decimal digit.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_converter #(
    parameter int VALUE_W    = 10,
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [VALUE_W-1:0]      i_value,
    output logic                    o_done,
    output logic [4*NUM_DIGITS-1:0] o_bcd
);

    localparam int c_cnt_w = $clog2(VALUE_W + 1);
    localparam int c_bcd_w = 4 * NUM_DIGITS;

    logic                       r_active;
    logic [c_cnt_w-1:0]         r_count;
    logic [VALUE_W-1:0]         r_shift;
    logic [c_bcd_w-1:0]         r_bcd;
    logic [c_bcd_w-1:0]         w_bcd_adj;
    logic [c_bcd_w+VALUE_W-1:0] w_shifted;

    // Add 3 to every nibble of 5 or more before it is doubled by the shift
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adjust
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          (r_bcd[4*gi +: 4] + 4'd3) :
                                          r_bcd[4*gi +: 4];
        end
    endgenerate

    assign w_shifted = {w_bcd_adj, r_shift} << 1;

    // Load on start, then shift binary bits into the BCD accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_count  <= '0;
            r_shift  <= '0;
            r_bcd    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_count  <= c_cnt_w'(VALUE_W);
            r_shift  <= i_value;
            r_bcd    <= '0;
        end else if (r_active) begin
            r_bcd    <= w_shifted[c_bcd_w+VALUE_W-1:VALUE_W];
            r_shift  <= w_shifted[VALUE_W-1:0];
            r_count  <= r_count - c_cnt_w'(1);
            if (r_count == c_cnt_w'(1)) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_done = r_active && (r_count == c_cnt_w'(1));
    assign o_bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/score_digit_writer.sv
`default_nettype none
// ============================================================================
//  Module   : score_digit_writer
//  Brief    : Renders a binary score as NUM_DIGITS decimal glyphs, copied
//             pixel by pixel from the glyph ROM into the 1-bit overlay
//             framebuffer, with leading-zero blanking.
//  Revision : 1.0  initial release
// ============================================================================
module score_digit_writer
    import numbers_pkg::*;
#(
    parameter int WIDTH      = c_glyph_width,
    parameter int HEIGHT     = c_glyph_height,
    parameter int NUM_IMGS   = c_glyph_num_imgs,
    parameter int NUM_DIGITS = 3,
    parameter int VALUE_W    = 10,
    parameter int FB_WIDTH   = NUM_DIGITS * WIDTH
) (
    input  logic                                       pixel_clk_in,
    input  logic                                       rst_in,
    input  logic                                       start_in,
    input  logic [VALUE_W-1:0]                         value_in,
    output logic                                       busy_out,
    output logic                                       done_out,
    output logic [$clog2(WIDTH*HEIGHT*NUM_IMGS)-1:0]   glyph_addr_out,
    input  logic                                       glyph_data_in,
    output logic [$clog2(FB_WIDTH*HEIGHT)-1:0]         fb_addr_out,
    output logic                                       fb_data_out,
    output logic                                       fb_we_out
);

    localparam int c_ga_w  = $clog2(WIDTH * HEIGHT * NUM_IMGS);
    localparam int c_fa_w  = $clog2(FB_WIDTH * HEIGHT);
    localparam int c_col_w = $clog2(WIDTH);
    localparam int c_row_w = $clog2(HEIGHT);
    localparam int c_dig_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_limit = pow10(NUM_DIGITS);

    writer_state_t             r_state;
    writer_state_t             w_next;
    logic [c_col_w-1:0]        r_col;
    logic [c_row_w-1:0]        r_row;
    logic [c_dig_w-1:0]        r_dig;
    logic                      r_drain;
    logic                      w_conv_start;
    logic                      w_conv_done;
    logic [4*NUM_DIGITS-1:0]   w_bcd;
    logic [VALUE_W-1:0]        w_value_sat;
    logic [3:0]                w_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     w_blank;
    logic                      w_zero_run;
    logic                      w_reading;
    logic                      w_last_read;
    logic [c_fa_w-1:0]         w_fb_addr;
    logic                      r_v1, r_v2;
    logic                      r_b1, r_b2;
    logic [c_fa_w-1:0]         r_fa1, r_fa2;

    // Clamp scores that do not fit into NUM_DIGITS decimal digits
    always_comb begin
        w_value_sat = value_in;
        if (32'(value_in) >= c_limit) begin
            w_value_sat = VALUE_W'(c_limit - 1);
        end
    end

    assign w_conv_start = (r_state == ST_IDLE) && start_in;

    bcd_converter #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bcd (
        .clk     (pixel_clk_in),
        .rst_n   (rst_in),
        .i_start (w_conv_start),
        .i_value (w_value_sat),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd)
    );

    // Digit 0 is the leftmost glyph, i.e. the most significant BCD nibble
    generate
        for (genvar gd = 0; gd < NUM_DIGITS; gd++) begin : g_digits
            assign w_digits[gd] = w_bcd[4*(NUM_DIGITS-1-gd) +: 4];
        end
    endgenerate

    // Blank leading zeros; the rightmost digit always stays visible
    always_comb begin
        w_zero_run = 1'b1;
        w_blank    = '0;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            w_zero_run = w_zero_run && (w_digits[i] == 4'd0);
            w_blank[i] = w_zero_run;
        end
    end

    assign w_reading   = (r_state == ST_COPY);
    assign w_last_read = w_reading &&
                         (r_dig == c_dig_w'(NUM_DIGITS - 1)) &&
                         (r_row == c_row_w'(HEIGHT - 1)) &&
                         (r_col == c_col_w'(WIDTH - 1));

    assign glyph_addr_out = c_ga_w'(w_digits[r_dig]) * c_ga_w'(WIDTH * HEIGHT) +
                            c_ga_w'(r_row) * c_ga_w'(WIDTH) +
                            c_ga_w'(r_col);
    assign w_fb_addr      = c_fa_w'(r_row) * c_fa_w'(FB_WIDTH) +
                            c_fa_w'(r_dig) * c_fa_w'(WIDTH) +
                            c_fa_w'(r_col);

    // State register
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_next   = r_state;
        busy_out = 1'b0;
        done_out = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_in) begin
                    w_next = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                busy_out = 1'b1;
                if (w_conv_done) begin
                    w_next = ST_COPY;
                end
            end
            ST_COPY: begin
                busy_out = 1'b1;
                if (w_last_read) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy_out = 1'b1;
                if (r_drain) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_out = 1'b1;
                w_next   = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Column, row, digit scan counters; they wrap to zero after the last read
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_col <= '0;
            r_row <= '0;
            r_dig <= '0;
        end else if (w_reading) begin
            if (r_col == c_col_w'(WIDTH - 1)) begin
                r_col <= '0;
                if (r_row == c_row_w'(HEIGHT - 1)) begin
                    r_row <= '0;
                    r_dig <= (r_dig == c_dig_w'(NUM_DIGITS - 1)) ? '0 : r_dig + c_dig_w'(1);
                end else begin
                    r_row <= r_row + c_row_w'(1);
                end
            end else begin
                r_col <= r_col + c_col_w'(1);
            end
        end
    end

    // Two drain cycles let the last reads emerge from the ROM
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_drain <= 1'b0;
        end else if (r_state == ST_DRAIN) begin
            r_drain <= ~r_drain;
        end else begin
            r_drain <= 1'b0;
        end
    end

    // Delay address and blank flag to line up with the 2-cycle ROM data
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_b1  <= 1'b0;
            r_b2  <= 1'b0;
            r_fa1 <= '0;
            r_fa2 <= '0;
        end else begin
            r_v1  <= w_reading;
            r_b1  <= w_reading && w_blank[r_dig];
            r_fa1 <= w_fb_addr;
            r_v2  <= r_v1;
            r_b2  <= r_b1;
            r_fa2 <= r_fa1;
        end
    end

    assign fb_we_out   = r_v2;
    assign fb_addr_out = r_fa2;
    assign fb_data_out = glyph_data_in & ~r_b2;

endmodule
`default_nettype wire
